// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the framed-stream program loader.
package riscv_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    // Default frame start marker
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Bytes per assembled memory word
    localparam int unsigned WORD_BYTES = 8;

    // Field widths of the registered memory write request
    localparam int unsigned PKG_IDX_W = 16;
    localparam int unsigned PKG_XLEN  = 64;

    typedef struct packed {
        logic                 we;
        logic [PKG_IDX_W-1:0] idx;
        logic [PKG_XLEN-1:0]  data;
    } mem_write_t;

endpackage

// File: rtl/riscv_prog_loader_word_asm.sv
// Little-endian word assembler: byte counter, 7-byte history and XOR checksum.
module loader_word_asm
    import riscv_loader_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [63:0] word_next,
    output logic        last_byte,
    output logic [7:0]  csum
);

    // Only the seven earlier bytes are held; the eighth is combined on the fly
    // so the completed word is available on the cycle its last byte arrives.
    logic [55:0] hist_q;
    logic [2:0]  bcnt_q;
    logic [7:0]  csum_q;

    assign word_next = {byte_in, hist_q};
    assign last_byte = (bcnt_q == 3'(WORD_BYTES - 1));
    assign csum      = csum_q;

    // Shift accepted bytes in at the top and fold them into the checksum
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            hist_q <= '0;
            bcnt_q <= '0;
            csum_q <= '0;
        end else if (push) begin
            hist_q <= word_next[63:8];
            bcnt_q <= bcnt_q + 3'd1;
            csum_q <= csum_q ^ byte_in;
        end
    end

endmodule

// File: rtl/riscv_prog_loader.sv
// Boot loader: frames a byte stream into 64-bit memory writes and holds the
// core in reset until the frame checksum has verified.
module riscv_prog_loader
    import riscv_loader_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter logic [63:0] RESETVEC  = 64'h0000_1000,
    parameter int unsigned MEM_IDX_W = 16,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [MEM_IDX_W-1:0] mem_widx,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_wready,
    output logic                 core_resetn,
    output logic                 load_done,
    output logic                 load_err
);

    localparam logic [MEM_IDX_W-1:0] BASE_IDX = MEM_IDX_W'(RESETVEC >> 3);

    loader_state_t        state_q;
    logic                 in_ready_q;
    mem_write_t           wr_q;
    logic                 core_resetn_q;
    logic                 load_done_q;
    logic                 load_err_q;
    logic [15:0]          len_q;
    logic [15:0]          wcnt_q;

    logic                 accept;
    logic                 sync_hit;
    logic                 start_frame;
    logic                 asm_push;
    logic [63:0]          word_next;
    logic                 last_byte;
    logic [7:0]           acc_csum;
    logic [MEM_IDX_W-1:0] idx_next;

    assign accept      = in_valid && in_ready_q;
    assign sync_hit    = accept && (in_data == SYNC_BYTE);
    assign start_frame = sync_hit &&
                         (state_q == S_SYNC || state_q == S_DONE || state_q == S_ERR);
    assign asm_push    = accept && (state_q == S_DATA);
    assign idx_next    = BASE_IDX + MEM_IDX_W'(wcnt_q);

    assign in_ready    = in_ready_q;
    assign mem_we      = wr_q.we;
    assign mem_widx    = MEM_IDX_W'(wr_q.idx);
    assign mem_wdata   = XLEN'(wr_q.data);
    assign core_resetn = core_resetn_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;

    loader_word_asm u_asm (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (start_frame),
        .push      (asm_push),
        .byte_in   (in_data),
        .word_next (word_next),
        .last_byte (last_byte),
        .csum      (acc_csum)
    );

    // Frame parser, write handshake and core reset control
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_SYNC;
            in_ready_q    <= 1'b1;
            wr_q          <= '0;
            core_resetn_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
            len_q         <= '0;
            wcnt_q        <= '0;
        end else begin
            unique case (state_q)
                S_SYNC, S_DONE, S_ERR: begin
                    if (start_frame) begin
                        state_q       <= S_LEN0;
                        wcnt_q        <= '0;
                        core_resetn_q <= 1'b0;
                        load_done_q   <= 1'b0;
                        load_err_q    <= 1'b0;
                    end
                end
                S_LEN0: begin
                    if (accept) begin
                        len_q[7:0] <= in_data;
                        state_q    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        len_q[15:8] <= in_data;
                        state_q     <= ({in_data, len_q[7:0]} == 16'd0) ? S_CSUM : S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept && last_byte) begin
                        state_q    <= S_WRITE;
                        in_ready_q <= 1'b0;
                        wr_q.we    <= 1'b1;
                        wr_q.idx   <= PKG_IDX_W'(idx_next);
                        wr_q.data  <= word_next;
                    end
                end
                S_WRITE: begin
                    if (mem_wready) begin
                        wr_q.we    <= 1'b0;
                        in_ready_q <= 1'b1;
                        wcnt_q     <= wcnt_q + 16'd1;
                        state_q    <= ((wcnt_q + 16'd1) == len_q) ? S_CSUM : S_DATA;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == acc_csum) begin
                            state_q       <= S_DONE;
                            core_resetn_q <= 1'b1;
                            load_done_q   <= 1'b1;
                        end else begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_prog_loader.sv
// Self-checking bench for riscv_prog_loader: directed scenarios plus random frames.
module tb_riscv_prog_loader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_widx;
    logic [63:0] mem_wdata;
    logic        mem_wready = 1'b1;
    logic        core_resetn;
    logic        load_done;
    logic        load_err;

    riscv_prog_loader #(
        .XLEN      (64),
        .RESETVEC  (64'h0000_1000),
        .MEM_IDX_W (16),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_widx    (mem_widx),
        .mem_wdata   (mem_wdata),
        .mem_wready  (mem_wready),
        .core_resetn (core_resetn),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    longint unsigned pcount = 0;

    always @(posedge clk) pcount++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory side: write capture, stall stability and wready generation
    int unsigned wready_mode = 0;
    int unsigned hold_left = 0;
    logic [15:0] got_idx[$];
    logic [63:0] got_data[$];
    int unsigned got_run[$];
    logic        stall_prev = 1'b0;
    logic [15:0] prev_idx = '0;
    logic [63:0] prev_data = '0;
    int unsigned we_run = 0;
    logic        wr_new;

    always @(negedge clk) begin
        #1;
        if (resetn && mem_we) begin
            chk("in_ready_low_while_we", 64'(in_ready), 64'd0);
            if (stall_prev) begin
                chk("widx_stable", 64'(mem_widx), 64'(prev_idx));
                chk("wdata_stable", mem_wdata, prev_data);
            end
            we_run++;
        end
        case (wready_mode)
            0: wr_new = 1'b1;
            1: wr_new = ($urandom_range(0, 2) != 0);
            default: begin
                if (mem_we && hold_left > 0) begin
                    wr_new = 1'b0;
                    hold_left--;
                end else begin
                    wr_new = 1'b1;
                end
            end
        endcase
        if (resetn && mem_we && wr_new) begin
            got_idx.push_back(mem_widx);
            got_data.push_back(mem_wdata);
            got_run.push_back(we_run);
            we_run     = 0;
            stall_prev = 1'b0;
        end else if (resetn && mem_we) begin
            stall_prev = 1'b1;
            prev_idx   = mem_widx;
            prev_data  = mem_wdata;
        end else begin
            stall_prev = 1'b0;
            we_run     = 0;
        end
        mem_wready = wr_new;
    end

    // Reference frame description
    logic [7:0]  payload[$];
    logic [15:0] exp_idx[$];
    logic [63:0] exp_data[$];

    // Present one byte (optionally after an idle gap) and return on the
    // falling edge after it was taken; in_valid is left high for back-to-back use.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned guard;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_garbage(input int unsigned n);
        logic [7:0] g;
        for (int unsigned i = 0; i < n; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, $urandom_range(0, 1));
        end
        in_valid = 1'b0;
    endtask

    // Send a frame built from `payload` and check memory writes and outcome
    task automatic run_frame(input int unsigned len, input logic [7:0] bad_mask,
                             input int unsigned gapmax, input string tag);
        logic [7:0]      xsum;
        logic [63:0]     w;
        bit              expect_ok;
        bit              timed;
        longint unsigned t0;
        exp_idx.delete();
        exp_data.delete();
        got_idx.delete();
        got_data.delete();
        got_run.delete();
        xsum = 8'h00;
        for (int unsigned i = 0; i < len; i++) begin
            w = 64'd0;
            for (int unsigned k = 0; k < 8; k++)
                w = w | (64'(payload[8*i+k]) << (8*k));
            exp_idx.push_back(16'((32'h1000 / 8 + i) % 65536));
            exp_data.push_back(w);
        end
        foreach (payload[j]) xsum = xsum ^ payload[j];
        expect_ok = (bad_mask == 8'h00);
        timed     = (gapmax == 0) && (wready_mode == 0) && (in_ready === 1'b1);
        t0        = pcount;

        send_byte(8'hA5, $urandom_range(0, gapmax));
        chk({tag, "_core_rst_on_sync"}, 64'(core_resetn), 64'd0);
        chk({tag, "_done_clr_on_sync"}, 64'(load_done), 64'd0);
        chk({tag, "_err_clr_on_sync"}, 64'(load_err), 64'd0);
        send_byte(8'(len), $urandom_range(0, gapmax));
        send_byte(8'(len >> 8), $urandom_range(0, gapmax));
        foreach (payload[j]) begin
            send_byte(payload[j], $urandom_range(0, gapmax));
            if (core_resetn !== 1'b0) chk({tag, "_core_held"}, 64'(core_resetn), 64'd0);
        end
        send_byte(xsum ^ bad_mask, $urandom_range(0, gapmax));
        in_valid = 1'b0;

        chk({tag, "_core_resetn"}, 64'(core_resetn), 64'(expect_ok));
        chk({tag, "_load_done"}, 64'(load_done), 64'(expect_ok));
        chk({tag, "_load_err"}, 64'(load_err), 64'(!expect_ok));
        if (timed) chk({tag, "_frame_cycles"}, 64'(pcount - t0), 64'(4 + 9 * len));
        chk({tag, "_nwrites"}, 64'(got_idx.size()), 64'(exp_idx.size()));
        if (got_idx.size() == exp_idx.size()) begin
            foreach (exp_idx[i]) begin
                chk({tag, "_widx"}, 64'(got_idx[i]), 64'(exp_idx[i]));
                chk({tag, "_wdata"}, got_data[i], exp_data[i]);
            end
        end
    endtask

    task automatic load_t1_payload();
        logic [63:0] p;
        p = 64'h0000_0000_0010_0073;
        payload.delete();
        for (int unsigned k = 0; k < 8; k++) payload.push_back(p[8*k +: 8]);
    endtask

    task automatic load_random_payload(input int unsigned len);
        payload.delete();
        for (int unsigned i = 0; i < 8 * len; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rlen;
        logic [7:0]  rmask;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_widx", 64'(mem_widx), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_core_resetn", 64'(core_resetn), 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_load_err", 64'(load_err), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single-word frame, no stalls
        wready_mode = 0;
        load_t1_payload();
        run_frame(1, 8'h00, 0, "t1");
        if (got_idx.size() == 1) begin
            chk("t1_idx_200", 64'(got_idx[0]), 64'h200);
            chk("t1_data", got_data[0], 64'h0000_0000_0010_0073);
        end

        // Same frame, checksum 64 instead of 63
        load_t1_payload();
        run_frame(1, 8'h07, 0, "t2");

        // Empty frame
        payload.delete();
        run_frame(0, 8'h00, 0, "t3");

        // Two words, first write stalled five cycles
        wready_mode = 2;
        hold_left   = 5;
        load_random_payload(2);
        run_frame(2, 8'h00, 0, "t4");
        if (got_run.size() == 2) begin
            chk("t4_we_cycles", 64'(got_run[0]), 64'd6);
            chk("t4_idx2", 64'(got_idx[1]), 64'h201);
        end
        wready_mode = 0;

        // Garbage before a valid frame
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h13, 0);
        in_valid = 1'b0;
        load_t1_payload();
        run_frame(1, 8'h00, 0, "t5");

        // Reset in the middle of DATA
        got_idx.delete();
        got_data.delete();
        got_run.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        in_valid = 1'b0;
        resetn   = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_core_resetn", 64'(core_resetn), 64'd0);
        chk("t6_mem_we", 64'(mem_we), 64'd0);
        chk("t6_load_done", 64'(load_done), 64'd0);
        for (int unsigned i = 0; i < 10; i++) send_byte(8'h44, 0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_no_writes", 64'(got_idx.size()), 64'd0);
        chk("t6_core_still_held", 64'(core_resetn), 64'd0);

        // Reload after DONE
        load_t1_payload();
        run_frame(1, 8'h00, 0, "t7a");
        chk("t7_released", 64'(core_resetn), 64'd1);
        load_random_payload(3);
        run_frame(3, 8'h00, 0, "t7b");

        // Random frames
        for (int unsigned it = 0; it < 10; it++) begin
            rlen        = $urandom_range(0, 5);
            rmask       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            wready_mode = $urandom_range(0, 1);
            send_garbage($urandom_range(0, 3));
            load_random_payload(rlen);
            run_frame(rlen, rmask, $urandom_range(0, 2), "rnd");
        end
        wready_mode = 0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
